// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and
//            single-cycle MTHI/MTLO writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_max_lat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_cnt_w   = $clog2(c_max_lat + 1);

    localparam logic [2:0] c_op_divu = 3'd3;
    localparam logic [2:0] c_op_mthi = 3'd4;
    localparam logic [2:0] c_op_mtlo = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    // op_q[1]: divide, op_q[0]: unsigned
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;

    logic [2*WIDTH-1:0]   w_a_sext, w_b_sext, w_a_zext, w_b_zext;
    logic [2*WIDTH-1:0]   w_prod_s, w_prod_u;
    logic                 w_div_zero, w_div_ovf;
    logic [WIDTH-1:0]     w_b_safe;
    logic signed [WIDTH-1:0] w_sq, w_sr;
    logic [WIDTH-1:0]     w_uq, w_ur;
    logic [WIDTH-1:0]     w_res_hi, w_res_lo;

    assign w_a_sext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign w_b_sext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign w_a_zext = {{WIDTH{1'b0}}, a_q};
    assign w_b_zext = {{WIDTH{1'b0}}, b_q};
    // Low 2*WIDTH bits of a product of extended operands give the exact result
    assign w_prod_s = w_a_sext * w_b_sext;
    assign w_prod_u = w_a_zext * w_b_zext;

    assign w_div_zero = (b_q == '0);
    assign w_div_ovf  = !op_q[0] && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    // Special cases are muxed out below; a safe divisor keeps the dividers defined
    assign w_b_safe   = (w_div_zero || w_div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;

    assign w_sq = $signed(a_q) / $signed(w_b_safe);
    assign w_sr = $signed(a_q) % $signed(w_b_safe);
    assign w_uq = a_q / w_b_safe;
    assign w_ur = a_q % w_b_safe;

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        if (!op_q[1]) begin
            if (op_q[0]) {w_res_hi, w_res_lo} = w_prod_u;
            else         {w_res_hi, w_res_lo} = w_prod_s;
        end else if (w_div_zero) begin
            w_res_hi = a_q;
            w_res_lo = '1;
        end else if (w_div_ovf) begin
            w_res_hi = '0;
            w_res_lo = a_q;
        end else if (op_q[0]) begin
            w_res_hi = w_ur;
            w_res_lo = w_uq;
        end else begin
            w_res_hi = w_sr;
            w_res_lo = w_sq;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op <= c_op_divu) begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        op_d    = op[1:0];
                        a_d     = a;
                        b_d     = b;
                        cnt_d   = op[1] ? c_cnt_w'(DIV_LAT) : c_cnt_w'(MUL_LAT);
                    end else if (op == c_op_mthi) begin
                        hi_d = a;
                    end else if (op == c_op_mtlo) begin
                        lo_d = a;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == c_cnt_w'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    hi_d    = w_res_hi;
                    lo_d    = w_res_lo;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Directed self-checking bench for mult_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Single-cycle MTHI/MTLO/no-op issue; returns at the negedge after the edge.
    task automatic issue1(input logic [2:0] o, input logic [31:0] va);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = 32'h0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Issue a multi-cycle op, optionally inject a second start while busy
    // after the inj_k-th busy cycle, then check exact latency and results.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] va, input logic [31:0] vb,
                          input int lat, input logic [31:0] eh, input logic [31:0] el,
                          input int inj_k, input logic [2:0] inj_op, input logic [31:0] inj_a);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0; op = 3'd7; a = $urandom; b = $urandom;
        chk({tag, " busy_first"}, {63'b0, busy}, 64'd1);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            chk({tag, " busy_hold"}, {62'b0, busy, done}, 64'd2);
            if (k == inj_k) begin
                start = 1'b1; op = inj_op; a = inj_a; b = 32'h3;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_done"}, {62'b0, busy, done}, 64'd1);
        chk({tag, " hilo"}, {hi, lo}, {eh, el});
        @(negedge clk);
        chk({tag, " done_clear"}, {62'b0, busy, done}, 64'd0);
        chk({tag, " hilo_hold"}, {hi, lo}, {eh, el});
    endtask

    initial begin
        int seen_done;
        reset = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("reset_state", {30'b0, busy, done, hi}, 64'd0);
        chk("reset_lo", {32'b0, lo}, 64'd0);

        // MTHI / MTLO / no-op in IDLE
        issue1(3'd4, 32'h12345678);
        chk("mthi", {30'b0, busy, done, hi}, {32'b0, 32'h12345678});
        issue1(3'd5, 32'hCAFEF00D);
        chk("mtlo", {30'b0, busy, done, lo}, {32'b0, 32'hCAFEF00D});
        issue1(3'd6, 32'h00000001);
        chk("noop", {hi, lo}, {32'h12345678, 32'hCAFEF00D});
        chk("noop_busy", {62'b0, busy, done}, 64'd0);

        // Reset mid-DIV aborts without writing HI/LO or pulsing done
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'hFFFFFFF9; b = 32'h2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("rst_mid_busy", {63'b0, busy}, 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        seen_done = 0;
        for (int k = 0; k < DIV_LAT + 2; k++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        chk("rst_no_done", 64'(seen_done), 64'd0);

        // MULT with an MTLO attempt while busy (must be ignored)
        run_op("mult", 3'd0, 32'hFFFFFFFD, 32'd7, MUL_LAT,
               32'hFFFFFFFF, 32'hFFFFFFEB, 2, 3'd5, 32'hDEADBEEF);
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT,
               32'hFFFFFFFE, 32'h00000001, 0, 3'd0, 32'h0);
        run_op("multu_small", 3'd1, 32'h00010000, 32'h00010000, MUL_LAT,
               32'h00000001, 32'h00000000, 0, 3'd0, 32'h0);
        run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, DIV_LAT,
               32'hFFFFFFFF, 32'hFFFFFFFD, 0, 3'd0, 32'h0);
        run_op("div_negb", 3'd2, 32'd7, 32'hFFFFFFFE, DIV_LAT,
               32'h00000001, 32'hFFFFFFFD, 0, 3'd0, 32'h0);
        run_op("divu_zero", 3'd3, 32'd7, 32'd0, DIV_LAT,
               32'h00000007, 32'hFFFFFFFF, 0, 3'd0, 32'h0);
        run_op("div_zero", 3'd2, 32'hFFFFFFF9, 32'd0, DIV_LAT,
               32'hFFFFFFF9, 32'hFFFFFFFF, 0, 3'd0, 32'h0);
        run_op("divu", 3'd3, 32'd100, 32'd7, DIV_LAT,
               32'h00000002, 32'h0000000E, 0, 3'd0, 32'h0);
        // Signed overflow with a MULT start injected while busy
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, DIV_LAT,
               32'h00000000, 32'h80000000, 3, 3'd0, 32'h00000002);
        run_op("divu_big", 3'd3, 32'h80000000, 32'hFFFFFFFF, DIV_LAT,
               32'h80000000, 32'h00000000, 0, 3'd0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
